// File: rtl/ball_packet_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ball_packet_tx
//  Purpose  : Snapshots ball state on a trigger and streams it to the peer
//             board as a byte packet over a valid/ready link, with a
//             one-deep pending buffer. Optional macro BALL_PKT_CHECKSUM_EN
//             appends an XOR checksum byte.
//  Revision : 1.0 - initial release
// ============================================================================
module ball_packet_tx #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic       ball_send_trigger,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_vy,
    input  logic [1:0] gravity_counter,
    input  logic [7:0] ball_speed_reg0,
    input  logic [7:0] ball_speed_reg1,
    input  logic [3:0] ball_speed_reg2,
    input  logic       game_over,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       pkt_done,
    output logic       pkt_overwrite
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef BALL_PKT_CHECKSUM_EN
    localparam logic [2:0] c_last_idx = 3'd6;
`else
    localparam logic [2:0] c_last_idx = 3'd5;
`endif

    // Snapshot layout: {speed2[39:36], grav[35:34], y[33:24], vy[23:16], s0[15:8], s1[7:0]}
    logic [39:0] w_snap;
    logic [39:0] r_cur,     w_cur_nxt;
    logic [39:0] r_pend,    w_pend_nxt;
    logic        r_pend_vld, w_pend_vld_nxt;
    logic [1:0]  r_state,   w_state_nxt;
    logic [2:0]  r_idx,     w_idx_nxt;
    logic        r_ovw,     w_ovw_nxt;
    logic        w_accept;
    logic        w_xfer;
    logic [7:0]  w_byte;
    logic [7:0]  w_b1, w_b2, w_b3, w_b4, w_b5;

    assign w_snap   = {ball_speed_reg2, gravity_counter, ball_y, ball_vy,
                       ball_speed_reg0, ball_speed_reg1};
    assign w_accept = ball_send_trigger & ~game_over;
    assign w_xfer   = (r_state == S_SEND) & tx_ready;

    assign w_b1 = r_cur[31:24];
    assign w_b2 = {r_cur[39:36], r_cur[35:34], r_cur[33:32]};
    assign w_b3 = r_cur[23:16];
    assign w_b4 = r_cur[15:8];
    assign w_b5 = r_cur[7:0];

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0:    w_byte = HEADER;
            3'd1:    w_byte = w_b1;
            3'd2:    w_byte = w_b2;
            3'd3:    w_byte = w_b3;
            3'd4:    w_byte = w_b4;
            3'd5:    w_byte = w_b5;
`ifdef BALL_PKT_CHECKSUM_EN
            3'd6:    w_byte = w_b1 ^ w_b2 ^ w_b3 ^ w_b4 ^ w_b5;
`endif
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cur_nxt      = r_cur;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_ovw_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A fresh trigger beats a stale pending snapshot
                if (w_accept) begin
                    w_cur_nxt      = w_snap;
                    w_state_nxt    = S_SEND;
                    w_idx_nxt      = 3'd0;
                    w_pend_vld_nxt = 1'b0;
                    w_ovw_nxt      = r_pend_vld;
                end else if (r_pend_vld) begin
                    w_cur_nxt      = r_pend;
                    w_state_nxt    = S_SEND;
                    w_idx_nxt      = 3'd0;
                    w_pend_vld_nxt = 1'b0;
                end
            end
            S_SEND: begin
                if (w_accept) begin
                    w_pend_nxt     = w_snap;
                    w_pend_vld_nxt = 1'b1;
                    w_ovw_nxt      = r_pend_vld;
                end
                if (w_xfer) begin
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = S_DONE;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_pend_nxt     = w_snap;
                    w_pend_vld_nxt = 1'b1;
                    w_ovw_nxt      = r_pend_vld;
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_cur      <= 40'd0;
            r_pend     <= 40'd0;
            r_pend_vld <= 1'b0;
            r_ovw      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cur      <= w_cur_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_ovw      <= w_ovw_nxt;
        end
    end

    assign tx_valid      = (r_state == S_SEND);
    assign tx_data       = tx_valid ? w_byte : 8'h00;
    assign busy          = (r_state != S_IDLE);
    assign pkt_done      = (r_state == S_DONE);
    assign pkt_overwrite = r_ovw;

endmodule
`default_nettype wire

// File: tb/tb_ball_packet_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ball_packet_tx
//  Purpose  : Self-checking bench for ball_packet_tx (honours
//             BALL_PKT_CHECKSUM_EN when defined).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ball_packet_tx;

`ifdef BALL_PKT_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    typedef struct {
        logic [9:0] y;
        logic [7:0] vy;
        logic [1:0] g;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [3:0] s2;
    } snap_t;

    typedef struct {
        snap_t      s;
        logic [7:0] b [7];
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, trig, go, rdy;
    logic [9:0] y;
    logic [7:0] vy, s0, s1;
    logic [1:0] grav;
    logic [3:0] s2;
    logic       tx_valid, busy, pkt_done, pkt_overwrite;
    logic [7:0] tx_data;

    int total = 0;
    int bad   = 0;

    // Reference model: current packet as a byte queue plus a one-slot pending store
    logic [7:0] m_bytes [$];
    bit         m_done, m_pend_v, m_ovw;
    snap_t      m_pend;

    logic [7:0] cap [$];
    int         done_seen, ovw_seen, busy_seen;

    ball_packet_tx #(.HEADER(8'hA5)) dut (
        .clk_25MHZ        (clk),
        .reset            (rst),
        .ball_send_trigger(trig),
        .ball_y           (y),
        .ball_vy          (vy),
        .gravity_counter  (grav),
        .ball_speed_reg0  (s0),
        .ball_speed_reg1  (s1),
        .ball_speed_reg2  (s2),
        .game_over        (go),
        .tx_ready         (rdy),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .busy             (busy),
        .pkt_done         (pkt_done),
        .pkt_overwrite    (pkt_overwrite)
    );

    always #20 clk = ~clk;

    function automatic logic [7:0] pbyte(snap_t s, int k);
        logic [7:0] b2;
        b2 = {s.s2, s.g, s.y[9:8]};
        case (k)
            0:       return 8'hA5;
            1:       return s.y[7:0];
            2:       return b2;
            3:       return s.vy;
            4:       return s.s0;
            5:       return s.s1;
            default: return s.y[7:0] ^ b2 ^ s.vy ^ s.s0 ^ s.s1;
        endcase
    endfunction

    function automatic snap_t cur_in();
        snap_t s;
        s.y = y; s.vy = vy; s.g = grav; s.s0 = s0; s.s1 = s1; s.s2 = s2;
        return s;
    endfunction

    task automatic set_in(snap_t s);
        y = s.y; vy = s.vy; grav = s.g; s0 = s.s0; s1 = s.s1; s2 = s.s2;
    endtask

    task automatic start_pkt(snap_t s);
        m_bytes = {};
        for (int k = 0; k < NB; k++) m_bytes.push_back(pbyte(s, k));
    endtask

    task automatic model_edge();
        bit acc, idle, nov;
        acc  = trig && !go;
        idle = (m_bytes.size() == 0) && !m_done;
        nov  = 1'b0;
        if (rst) begin
            m_bytes = {}; m_done = 0; m_pend_v = 0; m_ovw = 0;
            return;
        end
        if (idle) begin
            if (acc) begin
                start_pkt(cur_in());
                if (m_pend_v) begin m_pend_v = 0; nov = 1; end
            end else if (m_pend_v) begin
                start_pkt(m_pend);
                m_pend_v = 0;
            end
        end else begin
            if (acc) begin
                if (m_pend_v) nov = 1;
                m_pend = cur_in(); m_pend_v = 1;
            end
            if (m_done) m_done = 0;
            else if (rdy) begin
                void'(m_bytes.pop_front());
                if (m_bytes.size() == 0) m_done = 1;
            end
        end
        m_ovw = nov;
    endtask

    task automatic chk();
        bit ev;
        logic [7:0] ed;
        ev = (m_bytes.size() > 0);
        ed = ev ? m_bytes[0] : 8'h00;
        total++;
        if (tx_valid !== ev || tx_data !== ed || busy !== (ev || m_done) ||
            pkt_done !== m_done || pkt_overwrite !== m_ovw) begin
            bad++;
            $display("FAIL cycle t=%0t got v=%b d=%h busy=%b done=%b ovw=%b want v=%b d=%h busy=%b done=%b ovw=%b",
                     $time, tx_valid, tx_data, busy, pkt_done, pkt_overwrite,
                     ev, ed, ev || m_done, m_done, m_ovw);
        end
    endtask

    // Inputs are set after a falling edge; outputs are checked before the next rising edge
    task automatic tick(bit do_chk);
        if (do_chk) chk();
        if (tx_valid === 1'b1 && rdy) cap.push_back(tx_data);
        if (pkt_done === 1'b1) done_seen++;
        if (pkt_overwrite === 1'b1) ovw_seen++;
        if (busy === 1'b1) busy_seen++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clr_obs();
        cap = {}; done_seen = 0; ovw_seen = 0; busy_seen = 0;
    endtask

    task automatic expect_int(string nm, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic expect_byte(string nm, int k, logic [7:0] got, logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s byte%0d got=%h want=%h", nm, k, got, want);
        end
    endtask

    vec_t  tv [3];
    snap_t sa, sb, sc;

    initial begin
        tv[0].s = '{10'h155, 8'h12, 2'b10, 8'h34, 8'h56, 4'h3};
        tv[0].b = '{8'hA5, 8'h55, 8'h39, 8'h12, 8'h34, 8'h56, 8'h1C};
        tv[1].s = '{10'h3FF, 8'hFF, 2'b11, 8'h00, 8'hFF, 4'hF};
        tv[1].b = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};
        tv[2].s = '{10'h200, 8'h01, 2'b00, 8'h80, 8'h01, 4'h0};
        tv[2].b = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h80, 8'h01, 8'h82};

        rst = 1; trig = 0; go = 0; rdy = 1;
        set_in(tv[0].s);
        m_bytes = {}; m_done = 0; m_pend_v = 0; m_ovw = 0;
        @(negedge clk);
        tick(0);
        tick(1);
        rst = 0;
        total++;
        if (tx_valid !== 0 || tx_data !== 8'h00 || busy !== 0 || pkt_done !== 0 || pkt_overwrite !== 0) begin
            bad++;
            $display("FAIL reset_state got v=%b d=%h b=%b done=%b ovw=%b want all zero",
                     tx_valid, tx_data, busy, pkt_done, pkt_overwrite);
        end

        // Table-driven packets with tx_ready held high
        for (int i = 0; i < 3; i++) begin
            set_in(tv[i].s);
            trig = 1; tick(1); trig = 0;
            set_in('{10'h0, 8'h0, 2'b0, 8'h0, 8'h0, 4'h0});
            clr_obs();
            for (int c = 0; c < NB + 4; c++) tick(1);
            expect_int("vec_len", cap.size(), NB);
            expect_int("vec_done", done_seen, 1);
            for (int k = 0; k < NB && k < cap.size(); k++)
                expect_byte("vec", k, cap[k], tv[i].b[k]);
        end

        // Stall pattern 0,0,1 on tx_ready
        set_in(tv[0].s);
        trig = 1; rdy = 0; tick(1); trig = 0;
        clr_obs();
        for (int c = 0; c < 3 * NB + 6; c++) begin
            rdy = ((c % 3) == 2);
            tick(1);
        end
        rdy = 1;
        expect_int("stall_len", cap.size(), NB);
        for (int k = 0; k < NB && k < cap.size(); k++)
            expect_byte("stall", k, cap[k], tv[0].b[k]);

        // A, then B and C while A is sending: C replaces B
        sa = tv[0].s; sb = tv[1].s; sc = tv[2].s;
        clr_obs();
        set_in(sa); trig = 1; tick(1); trig = 0; tick(1);
        set_in(sb); trig = 1; tick(1); trig = 0; tick(1);
        set_in(sc); trig = 1; tick(1); trig = 0;
        for (int c = 0; c < 2 * NB + 8; c++) tick(1);
        expect_int("ovw_count", ovw_seen, 1);
        expect_int("abc_len", cap.size(), 2 * NB);
        for (int k = 0; k < 2 * NB && k < cap.size(); k++)
            expect_byte("abc", k, cap[k], (k < NB) ? tv[0].b[k] : tv[2].b[k - NB]);

        // Reset once B3 has been accepted (B4 on the bus)
        set_in(tv[1].s); trig = 1; tick(1); trig = 0;
        for (int c = 0; c < 20 && m_bytes.size() != NB - 4; c++) tick(1);
        expect_byte("mid_pos", 4, tx_data, tv[1].b[4]);
        clr_obs();
        rst = 1; tick(1); rst = 0;
        total++;
        if (tx_valid !== 0 || busy !== 0 || tx_data !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset got v=%b b=%b d=%h want v=0 b=0 d=00", tx_valid, busy, tx_data);
        end
        for (int c = 0; c < 4; c++) tick(1);
        expect_int("mid_no_done", done_seen, 0);
        set_in(tv[2].s); trig = 1; tick(1); trig = 0;
        expect_byte("fresh", 0, tx_data, 8'hA5);
        for (int c = 0; c < NB + 3; c++) tick(1);

        // game_over blocks new triggers
        clr_obs();
        go = 1; trig = 1; tick(1); trig = 0;
        for (int c = 0; c < 4; c++) tick(1);
        go = 0;
        expect_int("gameover_busy", busy_seen, 0);
        expect_int("gameover_cap", cap.size(), 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            trig = ($urandom_range(0, 7) == 0);
            go   = ($urandom_range(0, 15) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 299) == 0);
            y = 10'($urandom); vy = 8'($urandom); grav = 2'($urandom);
            s0 = 8'($urandom); s1 = 8'($urandom); s2 = 4'($urandom);
            tick(1);
        end
        rst = 0; trig = 0; rdy = 1;
        for (int c = 0; c < 2 * NB + 6; c++) tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
